// File: rtl/md_ctrl_if.sv
// Handshake bundle between md_ctrl and the shared multi-cycle multiply/divide unit.
// The controller drives the request side (master); the unit answers with busy and result (slave).
interface md_ctrl_if;
   logic        md_start;
   logic [1:0]  md_func;
   logic [31:0] md_a;
   logic [31:0] md_b;
   logic        md_busy;
   logic [31:0] md_hi;
   logic [31:0] md_lo;

   modport master (
      output md_start, md_func, md_a, md_b,
      input  md_busy, md_hi, md_lo
   );

   modport slave (
      input  md_start, md_func, md_a, md_b,
      output md_busy, md_hi, md_lo
   );
endinterface

// File: rtl/md_ctrl.sv
// Sequencing controller between the EX stage and the shared multiply/divide unit.
// Owns architectural HI/LO, issues one start pulse per op and stalls EX while a result is outstanding.
module md_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CW      = 7
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        div0,
   output logic        err,
   md_ctrl_if.master   md,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, DONE, DRAIN} state_e;

   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [1:0]    func_q, func_d;
   logic [31:0]   hi_d, lo_d;
   logic          div0_q, div0_d;
   logic          err_q, err_d;
   logic          drainGuard_q, drainGuard_d;
   logic          mdOp;
   logic          accept;
   logic          divZero;
   logic          timedOut;

   assign mdOp     = (op >= 4'd1) && (op <= 4'd8);
   assign stall    = op_valid && mdOp && (state_q != IDLE);
   assign accept   = op_valid && !stall && !flush;
   assign divZero  = ((op == 4'd3) || (op == 4'd4)) && (rt_val == '0);
   assign timedOut = (cnt_q == LAST);

   assign div0       = div0_q;
   assign err        = err_q;
   assign md.md_func = func_q;
   assign md.md_a    = a_q;
   assign md.md_b    = b_q;

   // Next-state and output decode for the issue/wait/commit sequence
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      func_d       = func_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      div0_d       = 1'b0;
      err_d        = 1'b0;
      drainGuard_d = 1'b0;
      md.md_start  = 1'b0;
      rd_valid     = 1'b0;
      rd_data      = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op)
                  4'd1, 4'd2, 4'd3, 4'd4: begin
                     if (divZero) begin
                        div0_d = 1'b1;
                     end else begin
                        a_d     = rs_val;
                        b_d     = rt_val;
                        func_d  = 2'(op - 4'd1);
                        state_d = ISSUE;
                     end
                  end
                  4'd5: begin
                     rd_valid = 1'b1;
                     rd_data  = hi_q;
                  end
                  4'd6: begin
                     rd_valid = 1'b1;
                     rd_data  = lo_q;
                  end
                  4'd7: hi_d = rs_val;
                  4'd8: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         ISSUE: begin
            md.md_start = 1'b1;
            cnt_d       = '0;
            if (flush) begin
               // The unit still sees this start pulse, so give it a cycle to raise busy
               drainGuard_d = 1'b1;
               state_d      = DRAIN;
            end else begin
               state_d = GUARD;
            end
         end
         GUARD: begin
            cnt_d   = '0;
            state_d = flush ? DRAIN : WAIT;
         end
         WAIT: begin
            if (flush) begin
               cnt_d   = '0;
               state_d = DRAIN;
            end else if (!md.md_busy) begin
               state_d = DONE;
            end else if (timedOut) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            hi_d    = md.md_hi;
            lo_d    = md.md_lo;
            state_d = IDLE;
         end
         DRAIN: begin
            if (drainGuard_q) begin
               cnt_d = '0;
            end else if (!md.md_busy) begin
               state_d = IDLE;
            end else if (timedOut) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand and HI/LO registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         func_q       <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         div0_q       <= 1'b0;
         err_q        <= 1'b0;
         drainGuard_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         func_q       <= func_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         div0_q       <= div0_d;
         err_q        <= err_d;
         drainGuard_q <= drainGuard_d;
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: behavioural mul/div unit with programmable latency,
// scoreboards for unit requests and mfhi/mflo reads, a vector table plus flush/timeout sequences.
module tb_md_ctrl;

   localparam int TIMEOUT = 8;
   localparam int CW      = 7;
   localparam int NV      = 12;

   logic        clk = 1'b0;
   logic        resetn;
   logic        op_valid;
   logic [3:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        stall;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        div0;
   logic        err;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   md_ctrl_if mdIf ();

   md_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .op_valid (op_valid),
      .op       (op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .flush    (flush),
      .stall    (stall),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .div0     (div0),
      .err      (err),
      .md       (mdIf),
      .hi_q     (hi_q),
      .lo_q     (lo_q)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cycle      = 0;
   int startCount = 0;
   int div0Count  = 0;
   int errCount   = 0;
   int startCycle = 0;
   int errCycle   = 0;

   typedef struct packed {
      logic [1:0]  func;
      logic [31:0] a;
      logic [31:0] b;
   } startExp_t;

   startExp_t   startQ[$];
   logic [31:0] rdQ[$];
   startExp_t   expS;
   logic [31:0] expRd;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
      end
   endtask

   // Behavioural multiply/divide unit; busy stays high for unitLat cycles after start
   int unsigned unitLat;
   logic        unitHold;
   int unsigned uCnt;
   logic [31:0] uA, uB;
   logic [1:0]  uFunc;

   function automatic logic [63:0] unitResult(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      logic [63:0]        r;
      sa = a;
      sb = b;
      r  = '0;
      case (f)
         2'b00: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         2'b01: r = {32'h0, a} * {32'h0, b};
         2'b10: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
         default: if (b != 0) r = {a % b, a / b};
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (!resetn) begin
         mdIf.md_busy <= 1'b0;
         mdIf.md_hi   <= '0;
         mdIf.md_lo   <= '0;
         uCnt         <= 0;
      end else if (mdIf.md_start) begin
         mdIf.md_busy <= 1'b1;
         uCnt         <= unitLat - 1;
         uA           <= mdIf.md_a;
         uB           <= mdIf.md_b;
         uFunc        <= mdIf.md_func;
      end else if (mdIf.md_busy && !unitHold) begin
         if (uCnt == 0) begin
            mdIf.md_busy <= 1'b0;
            {mdIf.md_hi, mdIf.md_lo} <= unitResult(uFunc, uA, uB);
         end else begin
            uCnt <= uCnt - 1;
         end
      end
   end

   initial forever begin
      @(posedge clk);
      cycle++;
   end

   // Output monitor: pops the scoreboards when the DUT produces a read or a unit request
   initial forever begin
      @(negedge clk);
      if (resetn === 1'b1) begin
         if (rd_valid === 1'b1) begin
            if (rdQ.size() == 0) begin
               checkOutput("rd_unexpected", 64'(rd_valid), 64'(0));
            end else begin
               expRd = rdQ.pop_front();
               checkOutput("rd_data", 64'(rd_data), 64'(expRd));
            end
         end
         if (mdIf.md_start === 1'b1) begin
            startCount++;
            startCycle = cycle;
            checkOutput("start_while_unit_busy", 64'(mdIf.md_busy), 64'(0));
            if (startQ.size() == 0) begin
               checkOutput("start_unexpected", 64'(mdIf.md_start), 64'(0));
            end else begin
               expS = startQ.pop_front();
               checkOutput("md_func", 64'(mdIf.md_func), 64'(expS.func));
               checkOutput("md_a", 64'(mdIf.md_a), 64'(expS.a));
               checkOutput("md_b", 64'(mdIf.md_b), 64'(expS.b));
            end
         end
         if (div0 === 1'b1) div0Count++;
         if (err === 1'b1) begin
            errCount++;
            errCycle = cycle;
         end
      end
   end

   // Presents an op just after a rising edge and holds it until the cycle it is accepted
   task automatic applyStimulus(input logic [3:0] o, input logic [31:0] rs, input logic [31:0] rt,
                                output int stallCycles);
      logic s;
      bit   done;
      op_valid    = 1'b1;
      op          = o;
      rs_val      = rs;
      rt_val      = rt;
      stallCycles = 0;
      done        = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         s = stall;
         @(posedge clk);
         #1;
         if (!s) begin
            done = 1'b1;
            break;
         end
         stallCycles++;
      end
      op_valid = 1'b0;
      op       = 4'd0;
      if (!done) checkOutput("accept_timeout", 64'(0), 64'(1));
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
      int          lat;
      int          expStart;
      logic [1:0]  expFunc;
      int          expDiv0;
      int          expStall;
      logic [31:0] expHi;
      logic [31:0] expLo;
   } vec_t;

   vec_t vec[NV];

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sc;
      int d0, s0, e0;
      vec_t v;

      vec[0]  = '{4'd2, 32'h0000_7fff, 32'h0000_0010, 5, 1, 2'b01, 0, 8, 32'h0000_0000, 32'h0007_fff0};
      vec[1]  = '{4'd4, 32'h0000_7fff, 32'h0000_0010, 5, 1, 2'b11, 0, 8, 32'h0000_000f, 32'h0000_07ff};
      vec[2]  = '{4'd1, 32'hffff_ffff, 32'h0000_0002, 3, 1, 2'b00, 0, 6, 32'hffff_ffff, 32'hffff_fffe};
      vec[3]  = '{4'd2, 32'hffff_ffff, 32'h0000_0002, 1, 1, 2'b01, 0, 4, 32'h0000_0001, 32'hffff_fffe};
      vec[4]  = '{4'd3, 32'hffff_fff9, 32'h0000_0002, 4, 1, 2'b10, 0, 7, 32'hffff_ffff, 32'hffff_fffd};
      vec[5]  = '{4'd3, 32'h0000_0005, 32'h0000_0000, 2, 0, 2'b00, 1, 0, 32'hffff_ffff, 32'hffff_fffd};
      vec[6]  = '{4'd4, 32'h0000_0005, 32'h0000_0000, 2, 0, 2'b00, 1, 0, 32'hffff_ffff, 32'hffff_fffd};
      vec[7]  = '{4'd7, 32'hdead_beef, 32'h0000_0000, 1, 0, 2'b00, 0, 0, 32'hdead_beef, 32'hffff_fffd};
      vec[8]  = '{4'd8, 32'h0bad_f00d, 32'h0000_0000, 1, 0, 2'b00, 0, 0, 32'hdead_beef, 32'h0bad_f00d};
      vec[9]  = '{4'd0, 32'h0000_0001, 32'h0000_0002, 1, 0, 2'b00, 0, 0, 32'hdead_beef, 32'h0bad_f00d};
      vec[10] = '{4'd12, 32'h0000_0003, 32'h0000_0004, 1, 0, 2'b00, 0, 0, 32'hdead_beef, 32'h0bad_f00d};
      vec[11] = '{4'd2, 32'h0001_0000, 32'h0001_0000, 2, 1, 2'b01, 0, 5, 32'h0000_0001, 32'h0000_0000};

      // Reset with a mult request held on the inputs
      resetn   = 1'b0;
      op_valid = 1'b1;
      op       = 4'd1;
      rs_val   = 32'h11;
      rt_val   = 32'h22;
      flush    = 1'b0;
      unitLat  = 1;
      unitHold = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("reset_hi", 64'(hi_q), 64'(0));
      checkOutput("reset_lo", 64'(lo_q), 64'(0));
      checkOutput("reset_start", 64'(mdIf.md_start), 64'(0));
      checkOutput("reset_stall", 64'(stall), 64'(0));
      checkOutput("reset_md_a", 64'(mdIf.md_a), 64'(0));
      checkOutput("reset_md_b", 64'(mdIf.md_b), 64'(0));
      checkOutput("reset_func", 64'(mdIf.md_func), 64'(0));
      checkOutput("reset_div0_err", 64'({div0, err}), 64'(0));
      op_valid = 1'b0;
      op       = 4'd0;
      @(posedge clk);
      #1;

      // Table: each op followed by mfhi held (stall measured) then mflo
      for (int i = 0; i < NV; i++) begin
         v       = vec[i];
         unitLat = v.lat;
         d0      = div0Count;
         s0      = startCount;
         if (v.expStart != 0) startQ.push_back({v.expFunc, v.rs, v.rt});
         applyStimulus(v.op, v.rs, v.rt, sc);
         rdQ.push_back(v.expHi);
         applyStimulus(4'd5, 32'h0, 32'h0, sc);
         checkOutput($sformatf("row%0d_stall_cycles", i), 64'(sc), 64'(v.expStall));
         rdQ.push_back(v.expLo);
         applyStimulus(4'd6, 32'h0, 32'h0, sc);
         @(negedge clk);
         checkOutput($sformatf("row%0d_hi", i), 64'(hi_q), 64'(v.expHi));
         checkOutput($sformatf("row%0d_lo", i), 64'(lo_q), 64'(v.expLo));
         checkOutput($sformatf("row%0d_div0_pulses", i), 64'(div0Count - d0), 64'(v.expDiv0));
         checkOutput($sformatf("row%0d_starts", i), 64'(startCount - s0), 64'(v.expStart));
         @(posedge clk);
         #1;
      end

      // Flush during WAIT of a long mult: result dropped, next op waits for busy to fall
      unitLat = 10;
      startQ.push_back({2'b00, 32'd3, 32'd5});
      applyStimulus(4'd1, 32'd3, 32'd5, sc);
      repeat (6) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      checkOutput("drain_hi", 64'(hi_q), 64'(1));
      checkOutput("drain_lo", 64'(lo_q), 64'(0));
      @(posedge clk);
      #1;
      unitLat = 2;
      startQ.push_back({2'b01, 32'd7, 32'd6});
      applyStimulus(4'd2, 32'd7, 32'd6, sc);
      checkOutput("drain_stall_cycles", 64'(sc), 64'(4));
      @(negedge clk);
      checkOutput("flushed_hi_kept", 64'(hi_q), 64'(1));
      checkOutput("flushed_lo_kept", 64'(lo_q), 64'(0));
      @(posedge clk);
      #1;
      rdQ.push_back(32'h0);
      applyStimulus(4'd5, 32'h0, 32'h0, sc);
      checkOutput("after_drain_stall", 64'(sc), 64'(4));
      rdQ.push_back(32'h2a);
      applyStimulus(4'd6, 32'h0, 32'h0, sc);
      checkOutput("flush_no_err", 64'(errCount), 64'(0));

      // Flush in IDLE blocks an mthi
      op_valid = 1'b1;
      op       = 4'd7;
      rs_val   = 32'h5555;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      op_valid = 1'b0;
      op       = 4'd0;
      @(negedge clk);
      checkOutput("idle_flush_blocks", 64'(hi_q), 64'(0));
      @(posedge clk);
      #1;

      // Timeout: unit never drops busy
      unitHold = 1'b1;
      unitLat  = 3;
      e0       = errCount;
      startQ.push_back({2'b00, 32'd2, 32'd3});
      applyStimulus(4'd1, 32'd2, 32'd3, sc);
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         if (errCount != e0) break;
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput("timeout_err_pulses", 64'(errCount - e0), 64'(1));
      checkOutput("timeout_latency", 64'(errCycle - startCycle), 64'(TIMEOUT + 2));
      checkOutput("timeout_hi_kept", 64'(hi_q), 64'(0));
      checkOutput("timeout_lo_kept", 64'(lo_q), 64'(32'h2a));
      applyStimulus(4'd7, 32'h1234, 32'h0, sc);
      checkOutput("mthi_after_timeout_stall", 64'(sc), 64'(0));
      @(negedge clk);
      checkOutput("mthi_after_timeout", 64'(hi_q), 64'(32'h1234));
      unitHold = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("late_result_ignored_hi", 64'(hi_q), 64'(32'h1234));
      checkOutput("late_result_ignored_lo", 64'(lo_q), 64'(32'h2a));
      checkOutput("start_queue_drained", 64'(startQ.size()), 64'(0));
      checkOutput("rd_queue_drained", 64'(rdQ.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
